lcd12864_bus_writer: RTL and testbench

- Physical-layer write engine for the ST7920-based LCD12864 8-bit parallel bus.
- Accepts one command or data byte per valid/ready handshake and drives lcd_rs/lcd_rw/lcd_en/lcd_dat with the required setup, enable-pulse and hold timing.
- Waits out the controller execution time before accepting the next byte.
- Sits directly downstream of the text/command sequencers, which no longer generate enable timing themselves.

---
 rtl/lcd12864_pkg.sv | 51 +++++
 rtl/lcd12864_bus_writer.sv | 199 +++++++++++++++++++
 tb/tb_lcd12864_bus_writer.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd12864_pkg.sv
// Shared types and constants for the LCD12864 (ST7920) parallel write engine.
// The optional power-up init sequence is enabled with the macro LCD12864_INIT_EN.
package lcd12864_pkg;

  // Engine states. PWRUP and INIT are reachable only when the init feature is built in.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    WAIT  = 3'd4,
    PWRUP = 3'd5,
    INIT  = 3'd6
  } lcd_state_e;

  // ST7920 basic instruction set commands.
  localparam logic [7:0] LCD_CMD_BASIC   = 8'h30;
  localparam logic [7:0] LCD_CMD_DISP_ON = 8'h0C;
  localparam logic [7:0] LCD_CMD_ENTRY   = 8'h06;
  localparam logic [7:0] LCD_CMD_CLEAR   = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME    = 8'h02;

  // DDRAM start addresses of the four text lines.
  localparam logic [7:0] LCD_LINE0_ADDR = 8'h80;
  localparam logic [7:0] LCD_LINE1_ADDR = 8'h90;
  localparam logic [7:0] LCD_LINE2_ADDR = 8'h88;
  localparam logic [7:0] LCD_LINE3_ADDR = 8'h98;

  // Clear (0x01) and Home (0x02/0x03) need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] dat);
    return !rs && ((dat == LCD_CMD_CLEAR) || (dat[7:1] == LCD_CMD_HOME[7:1]));
  endfunction

  // Byte written at each step of the power-up init sequence.
  function automatic logic [7:0] init_byte(input logic [1:0] step);
    logic [7:0] b;
    case (step)
      2'd0:    b = LCD_CMD_BASIC;
      2'd1:    b = LCD_CMD_DISP_ON;
      2'd2:    b = LCD_CMD_ENTRY;
      default: b = LCD_CMD_CLEAR;
    endcase
    return b;
  endfunction

  // Larger of two cycle counts, used to size the shared timing counter.
  function automatic int cyc_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd12864_bus_writer.sv
// Write-only physical-layer engine for the ST7920 LCD12864 8-bit parallel bus.
// One byte per valid/ready handshake; generates setup, enable pulse, hold and
// execution wait with a single reloading counter.
// Optional macro LCD12864_INIT_EN adds a power-up wait followed by the
// 0x30/0x0C/0x06/0x01 init sequence before the first upstream byte is accepted.
//
// Handshake: a byte transfers on a rising edge where wr_valid && wr_ready.
// wr_ready depends only on registered state; wr_valid seen while not ready is
// ignored, so upstream must hold the byte stable until it is accepted.
module lcd12864_bus_writer
  import lcd12864_pkg::*;
#(
  parameter int SETUP_CYC   = 4,
  parameter int EN_HIGH_CYC = 25,
  parameter int HOLD_CYC    = 4,
  parameter int EXEC_CYC    = 4000,
  parameter int CLEAR_CYC   = 90000,
  parameter int PWRUP_CYC   = 2500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_dat,
  output logic       busy,
  output logic       init_done
);

  localparam int MAX_CYC = cyc_max(cyc_max(cyc_max(SETUP_CYC, EN_HIGH_CYC),
                                           cyc_max(HOLD_CYC, EXEC_CYC)),
                                   cyc_max(CLEAR_CYC, PWRUP_CYC));
  localparam int CW = $clog2(MAX_CYC + 1);

  // Terminal counts: a phase of N cycles ends when the counter reaches N-1.
  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] EN_LAST    = CW'(EN_HIGH_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] EXEC_LAST  = CW'(EXEC_CYC - 1);
  localparam logic [CW-1:0] CLEAR_LAST = CW'(CLEAR_CYC - 1);
`ifdef LCD12864_INIT_EN
  localparam logic [CW-1:0] PWRUP_LAST = CW'(PWRUP_CYC - 1);
`endif

  lcd_state_e      r_state;
  lcd_state_e      w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic            r_rs;
  logic [7:0]      r_dat;
  logic            r_en;
  logic            w_init_done;
  logic            w_ready;
  logic            w_accept;
  logic            w_wait_last;
  logic            w_load;
  logic            w_load_rs;
  logic [7:0]      w_load_dat;

`ifdef LCD12864_INIT_EN
  logic            r_init_done;
  logic [1:0]      r_step;
  logic            w_init_fin;
  logic            w_step_inc;

  assign w_init_done = r_init_done;
`else
  assign w_init_done = 1'b1;
`endif

  assign w_ready  = (r_state == IDLE) && w_init_done;
  assign w_accept = wr_valid && w_ready;

  // The wait length follows the byte currently on the bus.
  assign w_wait_last = is_long_cmd(r_rs, r_dat) ? (r_cnt == CLEAR_LAST)
                                                : (r_cnt == EXEC_LAST);

  // Next-state and bus-load decode.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_rs   = wr_rs;
    w_load_dat  = wr_data;
`ifdef LCD12864_INIT_EN
    w_init_fin  = 1'b0;
    w_step_inc  = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = SETUP;
          w_load      = 1'b1;
        end
      end
      SETUP: begin
        if (r_cnt == SETUP_LAST) w_state_nxt = PULSE;
      end
      PULSE: begin
        if (r_cnt == EN_LAST) w_state_nxt = HOLD;
      end
      HOLD: begin
        if (r_cnt == HOLD_LAST) w_state_nxt = WAIT;
      end
      WAIT: begin
        if (w_wait_last) begin
`ifdef LCD12864_INIT_EN
          if (!r_init_done) begin
            if (r_step == 2'd3) begin
              w_state_nxt = IDLE;
              w_init_fin  = 1'b1;
            end else begin
              w_state_nxt = INIT;
              w_step_inc  = 1'b1;
            end
          end else begin
            w_state_nxt = IDLE;
          end
`else
          w_state_nxt = IDLE;
`endif
        end
      end
`ifdef LCD12864_INIT_EN
      PWRUP: begin
        if (r_cnt == PWRUP_LAST) w_state_nxt = INIT;
      end
      INIT: begin
        // Internal accept: puts the current init command on the bus.
        w_state_nxt = SETUP;
        w_load      = 1'b1;
        w_load_rs   = 1'b0;
        w_load_dat  = init_byte(r_step);
      end
`endif
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register and the shared phase counter, reloaded on every state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
`ifdef LCD12864_INIT_EN
      r_state <= PWRUP;
`else
      r_state <= IDLE;
`endif
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((w_state_nxt != r_state) || (r_state == IDLE)) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Bus registers: rs/dat change only at accept, en is high exactly in PULSE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rs  <= 1'b0;
      r_dat <= 8'h00;
      r_en  <= 1'b0;
    end else begin
      if (w_load) begin
        r_rs  <= w_load_rs;
        r_dat <= w_load_dat;
      end
      r_en <= (w_state_nxt == PULSE);
    end
  end

`ifdef LCD12864_INIT_EN
  // Init sequence progress and completion flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_step      <= 2'd0;
      r_init_done <= 1'b0;
    end else begin
      if (w_step_inc) r_step <= r_step + 2'd1;
      if (w_init_fin) r_init_done <= 1'b1;
    end
  end
`endif

  assign wr_ready  = w_ready;
  assign busy      = (r_state != IDLE);
  assign init_done = w_init_done;
  assign lcd_rs    = r_rs;
  assign lcd_rw    = 1'b0;
  assign lcd_en    = r_en;
  assign lcd_dat   = r_dat;

endmodule

// File: tb/tb_lcd12864_bus_writer.sv
// Directed self-checking bench for lcd12864_bus_writer.
// Timing parameters: SETUP=2, EN_HIGH=3, HOLD=2, EXEC=5, CLEAR=20, PWRUP=10,
// so a normal write is 12 cycles accept-to-ready and a Clear/Home is 27.
// Build with LCD12864_INIT_EN defined to also exercise the init sequence.
module tb_lcd12864_bus_writer;

  localparam int P_SETUP = 2;
  localparam int P_EN    = 3;
  localparam int P_HOLD  = 2;
  localparam int P_EXEC  = 5;
  localparam int P_CLEAR = 20;
  localparam int P_PWRUP = 10;
  localparam int LAT_NORM  = P_SETUP + P_EN + P_HOLD + P_EXEC;   // 12
  localparam int LAT_CLEAR = P_SETUP + P_EN + P_HOLD + P_CLEAR;  // 27
  localparam int TMO = 400;

`ifdef LCD12864_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic       wr_rs = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic [7:0] lcd_dat;
  logic       busy;
  logic       init_done;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int rel_cyc = 0;

  // Pulse monitor results.
  logic [8:0] pulse_q[$];
  int         rise_q[$];
  int         len_q[$];
  int         unstable = 0;
  logic       en_prev = 1'b0;
  int         en_len = 0;
  logic [8:0] cur_pulse = '0;

  lcd12864_bus_writer #(
    .SETUP_CYC  (P_SETUP),
    .EN_HIGH_CYC(P_EN),
    .HOLD_CYC   (P_HOLD),
    .EXEC_CYC   (P_EXEC),
    .CLEAR_CYC  (P_CLEAR),
    .PWRUP_CYC  (P_PWRUP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_rs    (wr_rs),
    .wr_data  (wr_data),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_en   (lcd_en),
    .lcd_dat  (lcd_dat),
    .busy     (busy),
    .init_done(init_done)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- enable pulse monitor (falling-edge sampling) ----------------
  always @(negedge clk) begin
    if (lcd_en && !en_prev) begin
      cur_pulse = {lcd_rs, lcd_dat};
      pulse_q.push_back(cur_pulse);
      rise_q.push_back(cyc);
      en_len = 1;
    end else if (lcd_en) begin
      en_len = en_len + 1;
      if ({lcd_rs, lcd_dat} !== cur_pulse) unstable = unstable + 1;
    end else if (en_prev) begin
      len_q.push_back(en_len);
    end
    en_prev = lcd_en;
  end

  task automatic clear_mon();
    pulse_q.delete();
    rise_q.delete();
    len_q.delete();
    unstable = 0;
  endtask

  // ---------------- driver tasks (called at #1 after a rising edge) ----------------
  task automatic send_byte(input logic rs, input logic [7:0] d, output int acc, output bit ok);
    wr_rs    = rs;
    wr_data  = d;
    wr_valid = 1'b1;
    ok  = 1'b0;
    acc = 0;
    for (int i = 0; i < TMO; i++) begin
      if (wr_ready) begin
        @(posedge clk); #1;
        acc = cyc;
        ok  = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
  endtask

  task automatic wait_ready(output int rc, output bit ok);
    ok = 1'b0;
    rc = 0;
    for (int i = 0; i < TMO; i++) begin
      @(posedge clk); #1;
      if (wr_ready) begin
        rc = cyc;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_init(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      if (init_done) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    rel_cyc = cyc;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (lcd_en !== 1'b0) $display("FAIL reset_en: got %b expected 0", lcd_en); else n_pass++;
    n_total++; if (lcd_rs !== 1'b0) $display("FAIL reset_rs: got %b expected 0", lcd_rs); else n_pass++;
    n_total++; if (lcd_dat !== 8'h00) $display("FAIL reset_dat: got %h expected 00", lcd_dat); else n_pass++;
    n_total++; if (lcd_rw !== 1'b0) $display("FAIL reset_rw: got %b expected 0", lcd_rw); else n_pass++;
    n_total++; if (busy !== INIT_EN) $display("FAIL reset_busy: got %b expected %b", busy, INIT_EN); else n_pass++;
    n_total++; if (wr_ready !== !INIT_EN) $display("FAIL reset_ready: got %b expected %b", wr_ready, !INIT_EN); else n_pass++;
    n_total++; if (init_done !== !INIT_EN) $display("FAIL reset_init_done: got %b expected %b", init_done, !INIT_EN); else n_pass++;
  endtask

`ifdef LCD12864_INIT_EN
  task automatic test_init();
    logic [8:0] exp_q[$];
    logic [8:0] got;
    logic [8:0] exp;
    int done_cyc;
    bit ok;
    clear_mon();
    exp_q = '{9'h030, 9'h00C, 9'h006, 9'h001};
    release_reset();
    n_total++; if (wr_ready !== 1'b0) $display("FAIL init_ready_low: got %b expected 0", wr_ready); else n_pass++;
    n_total++; if (init_done !== 1'b0) $display("FAIL init_done_low: got %b expected 0", init_done); else n_pass++;
    wait_init(ok);
    done_cyc = cyc;
    n_total++; if (ok !== 1'b1) $display("FAIL init_timeout: got %b expected 1", ok); else n_pass++;
    n_total++; if (wr_ready !== 1'b1) $display("FAIL init_ready_high: got %b expected 1", wr_ready); else n_pass++;
    n_total++;
    if (pulse_q.size() != 4) $display("FAIL init_pulse_count: got %0d expected 4", pulse_q.size());
    else n_pass++;
    while (exp_q.size() > 0 && pulse_q.size() > 0) begin
      got = pulse_q.pop_front();
      exp = exp_q.pop_front();
      n_total++; if (got !== exp) $display("FAIL init_byte: got %h expected %h", got, exp); else n_pass++;
    end
    if (rise_q.size() == 4) begin
      // PWRUP ends 10 edges after release, INIT latches on the next, en rises SETUP later.
      n_total++;
      if (rise_q[0] != rel_cyc + P_PWRUP + 1 + P_SETUP)
        $display("FAIL init_first_rise: got %0d expected %0d", rise_q[0], rel_cyc + P_PWRUP + 1 + P_SETUP);
      else n_pass++;
      n_total++;
      if (done_cyc - (rise_q[3] - P_SETUP) != LAT_CLEAR)
        $display("FAIL init_done_latency: got %0d expected %0d", done_cyc - (rise_q[3] - P_SETUP), LAT_CLEAR);
      else n_pass++;
    end
  endtask
`endif

  task automatic test_data_write();
    int acc, rc;
    bit ok, ok2;
    clear_mon();
    send_byte(1'b1, 8'h4C, acc, ok);
    n_total++; if (ok !== 1'b1) $display("FAIL dw_accept: got %b expected 1", ok); else n_pass++;
    n_total++; if (lcd_dat !== 8'h4C) $display("FAIL dw_dat: got %h expected 4c", lcd_dat); else n_pass++;
    n_total++; if (lcd_rs !== 1'b1) $display("FAIL dw_rs: got %b expected 1", lcd_rs); else n_pass++;
    n_total++; if (wr_ready !== 1'b0 || busy !== 1'b1) $display("FAIL dw_busy: got ready=%b busy=%b expected 0/1", wr_ready, busy); else n_pass++;
    wait_ready(rc, ok2);
    n_total++; if (!ok2 || rc - acc != LAT_NORM) $display("FAIL dw_latency: got %0d expected %0d", rc - acc, LAT_NORM); else n_pass++;
    n_total++;
    if (rise_q.size() != 1 || len_q.size() != 1) $display("FAIL dw_pulses: got %0d expected 1", rise_q.size());
    else begin
      n_pass++;
      n_total++; if (rise_q[0] - acc != P_SETUP) $display("FAIL dw_rise: got %0d expected %0d", rise_q[0] - acc, P_SETUP); else n_pass++;
      n_total++; if (len_q[0] != P_EN) $display("FAIL dw_en_len: got %0d expected %0d", len_q[0], P_EN); else n_pass++;
      n_total++; if (pulse_q[0] !== 9'h14C) $display("FAIL dw_pulse_byte: got %h expected 14c", pulse_q[0]); else n_pass++;
    end
  endtask

  task automatic test_clear_timing();
    logic [7:0] cmd_tab[4];
    int lat_tab[4];
    int acc, rc;
    bit ok, ok2;
    cmd_tab = '{8'h01, 8'h03, 8'h0C, 8'h02};
    lat_tab = '{LAT_CLEAR, LAT_CLEAR, LAT_NORM, LAT_CLEAR};
    for (int i = 0; i < 4; i++) begin
      send_byte(1'b0, cmd_tab[i], acc, ok);
      wait_ready(rc, ok2);
      n_total++;
      if (!ok || !ok2 || rc - acc != lat_tab[i])
        $display("FAIL clear_latency_%h: got %0d expected %0d", cmd_tab[i], rc - acc, lat_tab[i]);
      else n_pass++;
    end
    // Data 0x01 is not a command, so it takes the normal wait.
    send_byte(1'b1, 8'h01, acc, ok);
    wait_ready(rc, ok2);
    n_total++;
    if (!ok || !ok2 || rc - acc != LAT_NORM) $display("FAIL clear_data01_latency: got %0d expected %0d", rc - acc, LAT_NORM);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp_q[$];
    logic [8:0] byte_tab[4];
    logic [8:0] got;
    logic [8:0] exp;
    int acc[4];
    int rc;
    bit ok, timeout;
    clear_mon();
    byte_tab = '{9'h080, 9'h141, 9'h142, 9'h143};
    foreach (byte_tab[i]) exp_q.push_back(byte_tab[i]);
    timeout = 1'b0;
    {wr_rs, wr_data} = byte_tab[0];
    wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      acc[i] = 0;
      ok = 1'b0;
      for (int t = 0; t < TMO; t++) begin
        if (wr_ready) begin ok = 1'b1; break; end
        @(posedge clk); #1;
      end
      if (!ok) timeout = 1'b1;
      @(posedge clk); #1;
      acc[i] = cyc;
      if (i < 3) {wr_rs, wr_data} = byte_tab[i+1];
      else wr_valid = 1'b0;
    end
    wr_valid = 1'b0;
    wait_ready(rc, ok);
    n_total++; if (timeout || !ok) $display("FAIL b2b_timeout: got %b expected 0", timeout || !ok); else n_pass++;
    n_total++; if (pulse_q.size() != 4) $display("FAIL b2b_pulse_count: got %0d expected 4", pulse_q.size()); else n_pass++;
    while (exp_q.size() > 0 && pulse_q.size() > 0) begin
      got = pulse_q.pop_front();
      exp = exp_q.pop_front();
      n_total++; if (got !== exp) $display("FAIL b2b_byte: got %h expected %h", got, exp); else n_pass++;
    end
    // Ready returns 12 cycles after accept; the handshake takes one more IDLE cycle.
    for (int i = 1; i < 4; i++) begin
      n_total++;
      if (acc[i] - acc[i-1] != LAT_NORM + 1)
        $display("FAIL b2b_spacing_%0d: got %0d expected %0d", i, acc[i] - acc[i-1], LAT_NORM + 1);
      else n_pass++;
    end
    n_total++; if (unstable != 0) $display("FAIL b2b_stable: got %0d expected 0", unstable); else n_pass++;
    foreach (len_q[i]) begin
      n_total++; if (len_q[i] != P_EN) $display("FAIL b2b_en_len: got %0d expected %0d", len_q[i], P_EN); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_pulse();
    int acc, rc;
    bit ok, ok2;
    clear_mon();
    send_byte(1'b1, 8'h55, acc, ok);
    ok2 = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      if (lcd_en) begin ok2 = 1'b1; break; end
      @(posedge clk); #1;
    end
    n_total++; if (!ok || !ok2) $display("FAIL rmp_reach_pulse: got %b expected 1", ok && ok2); else n_pass++;
    rst = 1'b1;
    #1;
    n_total++; if (lcd_en !== 1'b0) $display("FAIL rmp_en: got %b expected 0", lcd_en); else n_pass++;
    n_total++; if (lcd_dat !== 8'h00 || lcd_rs !== 1'b0) $display("FAIL rmp_bus: got %b/%h expected 0/00", lcd_rs, lcd_dat); else n_pass++;
    n_total++; if (busy !== INIT_EN) $display("FAIL rmp_busy: got %b expected %b", busy, INIT_EN); else n_pass++;
    release_reset();
    if (INIT_EN) begin
      wait_init(ok);
      n_total++; if (!ok) $display("FAIL rmp_init_timeout: got %b expected 1", ok); else n_pass++;
    end
    clear_mon();
    send_byte(1'b0, 8'h0C, acc, ok);
    wait_ready(rc, ok2);
    n_total++; if (!ok || !ok2 || rc - acc != LAT_NORM) $display("FAIL rmp_latency: got %0d expected %0d", rc - acc, LAT_NORM); else n_pass++;
    n_total++;
    if (pulse_q.size() != 1) $display("FAIL rmp_pulses: got %0d expected 1", pulse_q.size());
    else begin
      n_pass++;
      n_total++; if (pulse_q[0] !== 9'h00C) $display("FAIL rmp_byte: got %h expected 00c", pulse_q[0]); else n_pass++;
      n_total++; if (rise_q[0] - acc != P_SETUP || len_q[0] != P_EN)
        $display("FAIL rmp_timing: got rise %0d len %0d expected %0d/%0d", rise_q[0] - acc, len_q[0], P_SETUP, P_EN);
      else n_pass++;
    end
  endtask

  task automatic test_busy_ignore();
    int acc, rc;
    bit ok, ok2;
    int bad;
    clear_mon();
    send_byte(1'b1, 8'h41, acc, ok);
    wr_valid = 1'b1;
    wr_rs    = 1'b0;
    wr_data  = 8'h5A;
    bad = 0;
    ok2 = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      if (lcd_dat !== 8'h41 || lcd_rs !== 1'b1) bad++;
      if (wr_ready) begin ok2 = 1'b1; break; end
      @(posedge clk); #1;
    end
    n_total++; if (bad != 0) $display("FAIL busy_hold: got %0d changes expected 0", bad); else n_pass++;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    n_total++; if (!ok || !ok2 || lcd_dat !== 8'h5A || lcd_rs !== 1'b0)
      $display("FAIL busy_next_accept: got %b/%h expected 0/5a", lcd_rs, lcd_dat);
    else n_pass++;
    wait_ready(rc, ok);
    n_total++; if (pulse_q.size() != 2) $display("FAIL busy_pulse_count: got %0d expected 2", pulse_q.size()); else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
`ifdef LCD12864_INIT_EN
    test_init();
`else
    release_reset();
`endif
    test_data_write();
    test_clear_timing();
    test_back_to_back();
    test_reset_mid_pulse();
    test_busy_ignore();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
